mux: RTL and testbench

Two-input, WIDTH-bit selector for the LittleComputer elementary-logic layer. Y follows A when S = 0 and B when S = 1, combinationally, with no clock in that path. A clocked, resettable copy of the selected value (YQ) and a select-change flag (SCHG) feed the downstream register and datapath blocks. The data path is built from the elementary NOT/AND/OR gates, not from behavioural operators.

---
 rtl/mux_pkg.sv | 6 +
 rtl/mux_if.sv | 26 ++
 rtl/mux_bit.sv | 18 +
 rtl/mux.sv | 57 +++++
 tb/tb_mux.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants for the elementary-logic 2:1 selector
package mux_pkg;

  localparam int MUX_DEFAULT_WIDTH = 1;

endpackage

// File: rtl/mux_if.sv
// rtl/mux_if.sv - select/data/enable bundle and results of the 2:1 selector
interface mux_if
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_DEFAULT_WIDTH
);

  logic             S;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             EN;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] YQ;
  logic             SCHG;

  modport master (
    output S, A, B, EN,
    input  Y, YQ, SCHG
  );

  modport slave (
    input  S, A, B, EN,
    output Y, YQ, SCHG
  );

endinterface

// File: rtl/mux_bit.sv
// rtl/mux_bit.sv - single-bit 2:1 mux from one NOT, two AND and one OR gate
module mux_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic s_i,
  output logic y_o
);

  logic s_n;
  logic a_term;
  logic b_term;

  not u_not   (s_n,    s_i);
  and u_and_a (a_term, a_i, s_n);
  and u_and_b (b_term, b_i, s_i);
  or  u_or    (y_o,    a_term, b_term);

endmodule

// File: rtl/mux.sv
// rtl/mux.sv - WIDTH-bit gate-level selector with registered copy and select-change flag
module mux
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_DEFAULT_WIDTH
) (
  input logic   CLK,
  input logic   RST_N,
  mux_if.slave  bus
);

  logic [WIDTH-1:0] y_w;
  logic [WIDTH-1:0] yq_d;
  logic [WIDTH-1:0] yq_q;
  logic             s_last_d;
  logic             s_last_q;
  logic             schg_d;
  logic             schg_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux_bit u_bit (
      .a_i (bus.A[i]),
      .b_i (bus.B[i]),
      .s_i (bus.S),
      .y_o (y_w[i])
    );
  end

  // SCHG compares against the select of the previous load, not the previous cycle
  always_comb begin
    yq_d     = yq_q;
    s_last_d = s_last_q;
    schg_d   = 1'b0;
    if (bus.EN) begin
      yq_d     = y_w;
      s_last_d = bus.S;
      schg_d   = bus.S ^ s_last_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      yq_q     <= '0;
      s_last_q <= 1'b0;
      schg_q   <= 1'b0;
    end else begin
      yq_q     <= yq_d;
      s_last_q <= s_last_d;
      schg_q   <= schg_d;
    end
  end

  assign bus.Y    = y_w;
  assign bus.YQ   = yq_q;
  assign bus.SCHG = schg_q;

endmodule

// File: tb/tb_mux.sv
// tb/tb_mux.sv - self-checking bench for the mux selector at WIDTH 1 and 8
module tb_mux;

  logic clk1;
  logic rst1_n;
  logic clk8;
  logic rst8_n;

  int tests;
  int fails;

  logic [7:0] m_yq;
  logic       m_slast;
  logic       m_schg;

  mux_if #(.WIDTH(1)) if1 ();
  mux_if #(.WIDTH(8)) if8 ();

  mux #(.WIDTH(1)) dut1 (
    .CLK   (clk1),
    .RST_N (rst1_n),
    .bus   (if1)
  );

  mux #(.WIDTH(8)) dut8 (
    .CLK   (clk8),
    .RST_N (rst8_n),
    .bus   (if8)
  );

  initial clk8 = 1'b0;
  always #5 clk8 = ~clk8;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clocked step of the 8-bit DUT: drive just after an edge, check Y, then the edge result.
  task automatic step8(input logic rst, input logic s, input logic [7:0] a,
                       input logic [7:0] b, input logic en);
    logic [7:0] sel;
    rst8_n = rst;
    if8.S  = s;
    if8.A  = a;
    if8.B  = b;
    if8.EN = en;
    sel = s ? b : a;
    if (!rst) begin
      m_yq    = 8'h00;
      m_slast = 1'b0;
      m_schg  = 1'b0;
    end
    #1;
    check("y_comb", 64'(if8.Y), 64'(sel));
    if (!rst) begin
      check("yq_async_rst", 64'(if8.YQ), 64'h0);
      check("schg_async_rst", 64'(if8.SCHG), 64'h0);
    end
    @(posedge clk8);
    if (rst) begin
      if (en) begin
        m_schg  = (s != m_slast);
        m_slast = s;
        m_yq    = sel;
      end else begin
        m_schg = 1'b0;
      end
    end
    #1;
    check("yq", 64'(if8.YQ), 64'(m_yq));
    check("schg", 64'(if8.SCHG), 64'(m_schg));
  endtask

  initial begin
    logic [7:0] tt;
    logic [4:0] exp_schg;
    logic [4:0] seq_s;
    tests   = 0;
    fails   = 0;
    m_yq    = 8'h00;
    m_slast = 1'b0;
    m_schg  = 1'b0;
    tt       = 8'b1010_1100;
    seq_s    = 5'b01100;
    exp_schg = 5'b10100;

    // Exhaustive truth table on the 1-bit DUT, no clock and reset held
    clk1   = 1'b0;
    rst1_n = 1'b0;
    if1.EN = 1'b1;
    rst8_n = 1'b0;
    if8.S  = 1'b0;
    if8.A  = 8'h00;
    if8.B  = 8'h00;
    if8.EN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {if1.S, if1.A, if1.B} = v;
      #1;
      check($sformatf("tt_%0d", i), 64'(if1.Y), 64'(tt[i]));
    end
    check("w1_yq_rst", 64'(if1.YQ), 64'h0);
    // Edges on the 1-bit DUT with reset low and EN high must not load
    for (int i = 0; i < 2; i++) begin
      #2 clk1 = 1'b1;
      #2 clk1 = 1'b0;
    end
    check("w1_yq_rst_edges", 64'(if1.YQ), 64'h0);
    check("w1_schg_rst_edges", 64'(if1.SCHG), 64'h0);

    // 8-bit reset state, then wide select and first load
    @(posedge clk8);
    #1;
    check("w8_yq_reset", 64'(if8.YQ), 64'h0);
    check("w8_schg_reset", 64'(if8.SCHG), 64'h0);
    step8(1'b1, 1'b0, 8'hA5, 8'h3C, 1'b0);
    check("wide_s0_y", 64'(if8.Y), 64'hA5);
    step8(1'b1, 1'b1, 8'hA5, 8'h3C, 1'b1);
    check("wide_load_yq", 64'(if8.YQ), 64'h3C);
    check("wide_load_schg", 64'(if8.SCHG), 64'h1);

    // Enable hold over three edges with changing inputs
    for (int i = 0; i < 3; i++) begin
      step8(1'b1, 1'(i), 8'($urandom), 8'($urandom), 1'b0);
      check("hold_yq", 64'(if8.YQ), 64'h3C);
      check("hold_schg", 64'(if8.SCHG), 64'h0);
    end

    // Select-change sequence after a fresh reset
    step8(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step8(1'b1, seq_s[i], 8'h11, 8'h22, 1'b1);
      check($sformatf("schg_seq_%0d", i), 64'(if8.SCHG), 64'(exp_schg[i]));
    end

    // Async reset mid-cycle with YQ = 0x3C
    step8(1'b1, 1'b1, 8'hA5, 8'h3C, 1'b1);
    check("pre_async_yq", 64'(if8.YQ), 64'h3C);
    #2;
    rst8_n = 1'b0;
    m_yq    = 8'h00;
    m_slast = 1'b0;
    m_schg  = 1'b0;
    #1;
    check("async_yq", 64'(if8.YQ), 64'h0);
    check("async_schg", 64'(if8.SCHG), 64'h0);
    if8.S = 1'b0;
    #1;
    check("async_y_tracks", 64'(if8.Y), 64'hA5);

    // Reset wins over load, then first load after release with S = 1
    step8(1'b0, 1'b1, 8'h5A, 8'hC3, 1'b1);
    check("rst_vs_load_yq", 64'(if8.YQ), 64'h0);
    step8(1'b1, 1'b1, 8'h5A, 8'hC3, 1'b1);
    check("first_load_schg", 64'(if8.SCHG), 64'h1);
    check("first_load_yq", 64'(if8.YQ), 64'hC3);

    // Randomised run against the reference model, with occasional resets
    for (int i = 0; i < 300; i++) begin
      step8(($urandom_range(0, 15) != 0), 1'($urandom), 8'($urandom),
            8'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
